mips_exec_unit: RTL and testbench



---
 rtl/mips_exec_unit.sv | 179 +++++++++++++++++
 tb/tb_mips_exec_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: decode + execute slice of the 5-stage MIPS pipeline.
// Decodes ir, runs the ALU and branch/jump resolution on already-forwarded
// operands, and registers the results into the EX/MEM pipeline register.
// Optional build macro: EXU_MULDIV_EN enables the MUL/DIVU ALU operations.
module mips_exec_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic [31:0] ir,
  input  logic [31:0] pc4,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [4:0]  r1_idx,
  output logic [4:0]  r2_idx,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] m_pc,
  output logic [31:0] m_ir,
  output logic [31:0] m_alu,
  output logic [31:0] m_b,
  output logic [31:0] m_link,
  output logic [4:0]  m_wr,
  output logic        m_regwrite,
  output logic        m_memwrite,
  output logic        m_memtoreg,
  output logic        m_jal,
  output logic        m_sh,
  output logic        m_syscall,
  output logic        m_halt
);

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRA, ALU_SRL, ALU_MUL, ALU_DIVU, ALU_ADD, ALU_SUB,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
    OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
    OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
    OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SH = 6'h29, OP_SW = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
    FN_SYSCALL = 6'h0C, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
    FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
    FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B
  } funct_t;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  alu_op_t     alu_op;
  logic        regwrite, memwrite, memtoreg, jal, sh, syscall;
  logic        use_imm, zext, shift, br_eq, br_ne, br_gez, jump, jr;
  logic [4:0]  wr;
  logic [31:0] imm, simm, x, y, alu_y;
  logic        equal;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign fn    = ir[5:0];

  // Instruction decode into control signals; unknown encodings stay NOP.
  always_comb begin
    alu_op   = ALU_ADD;
    regwrite = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; jal = 1'b0;
    sh       = 1'b0; syscall  = 1'b0; use_imm  = 1'b0; zext = 1'b0;
    shift    = 1'b0; br_eq    = 1'b0; br_ne    = 1'b0; br_gez = 1'b0;
    jump     = 1'b0; jr       = 1'b0; wr       = '0;
    case (op)
      OP_RTYPE: begin
        wr       = rd;
        regwrite = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  begin alu_op = ALU_SLL; shift = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; shift = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; shift = 1'b1; end
          FN_JR:      begin jr = 1'b1; regwrite = 1'b0; end
          FN_SYSCALL: begin syscall = 1'b1; regwrite = 1'b0; end
          default: begin regwrite = 1'b0; wr = '0; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; alu_op = ALU_ADD; end
      OP_SLTI:  begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU: begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR; end
      OP_XORI:  begin wr = rt; regwrite = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_XOR; end
      OP_LW:    begin wr = rt; regwrite = 1'b1; memtoreg = 1'b1; use_imm = 1'b1; end
      OP_SW:    begin memwrite = 1'b1; use_imm = 1'b1; end
      OP_SH:    begin memwrite = 1'b1; sh = 1'b1; use_imm = 1'b1; end
      OP_BEQ:   begin br_eq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:   begin br_ne = 1'b1; alu_op = ALU_SUB; end
      OP_REGIMM: br_gez = (rt == 5'd1);
      OP_J:     jump = 1'b1;
      OP_JAL:   begin jump = 1'b1; jal = 1'b1; regwrite = 1'b1; wr = 5'd31; end
      default: ;
    endcase
  end

  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign imm  = zext ? {16'b0, ir[15:0]} : simm;

  // Shifts put the value on X and the shift amount on Y.
  assign x = shift ? b : a;
  assign y = shift ? {27'b0, shamt} : use_imm ? imm : syscall ? 32'd10 : b;
  assign equal = (x == y);

  // ALU datapath.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_SLL:  alu_y = x << y[4:0];
      ALU_SRA:  alu_y = $signed(x) >>> y[4:0];
      ALU_SRL:  alu_y = x >> y[4:0];
`ifdef EXU_MULDIV_EN
      ALU_MUL:  alu_y = x * y;
      ALU_DIVU: alu_y = (y == '0) ? '0 : x / y;
`else
      ALU_MUL, ALU_DIVU: alu_y = '0;
`endif
      ALU_ADD:  alu_y = x + y;
      ALU_SUB:  alu_y = x - y;
      ALU_AND:  alu_y = x & y;
      ALU_OR:   alu_y = x | y;
      ALU_XOR:  alu_y = x ^ y;
      ALU_NOR:  alu_y = ~(x | y);
      ALU_SLT:  alu_y = {31'b0, $signed(x) < $signed(y)};
      ALU_SLTU: alu_y = {31'b0, x < y};
      default:  alu_y = '0;
    endcase
  end

  // Branch/jump resolution and read-index steering.
  always_comb begin
    taken  = (br_eq & equal) | (br_ne & ~equal) | (br_gez & ~a[31]) | jump | jr;
    target = jr   ? a :
             jump ? {pc4[31:28], ir[25:0], 2'b00} :
                    pc4 + {simm[29:0], 2'b00};
    r1_idx = syscall ? 5'd2 : rs;
    r2_idx = syscall ? 5'd4 : rt;
  end

  // EX/MEM pipeline register; clr and flush both load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      m_pc <= '0; m_ir <= '0; m_alu <= '0; m_b <= '0; m_link <= '0; m_wr <= '0;
      m_regwrite <= 1'b0; m_memwrite <= 1'b0; m_memtoreg <= 1'b0; m_jal <= 1'b0;
      m_sh <= 1'b0; m_syscall <= 1'b0; m_halt <= 1'b0;
    end else begin
      m_pc       <= taken ? target : pc4;
      m_ir       <= ir;
      m_alu      <= alu_y;
      m_b        <= b;
      m_link     <= pc4;
      m_wr       <= wr;
      m_regwrite <= regwrite;
      m_memwrite <= memwrite;
      m_memtoreg <= memtoreg;
      m_jal      <= jal;
      m_sh       <= sh;
      m_syscall  <= syscall;
      m_halt     <= syscall && (a == 32'd10);
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Testbench for mips_exec_unit: directed vector table, hand-written
// clr/flush sequences, and randomized instructions against a reference model.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        clr, flush;
  logic [31:0] ir, pc4, a, b;
  logic [4:0]  r1_idx, r2_idx, m_wr;
  logic        taken;
  logic [31:0] target, m_pc, m_ir, m_alu, m_b, m_link;
  logic        m_regwrite, m_memwrite, m_memtoreg, m_jal, m_sh, m_syscall, m_halt;

  int total = 0;
  int bad   = 0;

  mips_exec_unit dut (
    .clk(clk), .clr(clr), .flush(flush), .ir(ir), .pc4(pc4), .a(a), .b(b),
    .r1_idx(r1_idx), .r2_idx(r2_idx), .taken(taken), .target(target),
    .m_pc(m_pc), .m_ir(m_ir), .m_alu(m_alu), .m_b(m_b), .m_link(m_link),
    .m_wr(m_wr), .m_regwrite(m_regwrite), .m_memwrite(m_memwrite),
    .m_memtoreg(m_memtoreg), .m_jal(m_jal), .m_sh(m_sh),
    .m_syscall(m_syscall), .m_halt(m_halt)
  );

  always #5 clk = ~clk;

  // Expected outputs; ctl = {regwrite,memwrite,memtoreg,jal,sh,syscall,halt}.
  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic        alu_ok;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [6:0]  ctl;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] ir, pc4, a, b;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input logic tk, input logic [31:0] tgt, input logic aok,
                                input logic [31:0] alu, input logic [4:0] wr,
                                input logic [6:0] ctl, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    e.taken = tk; e.tgt = tgt; e.alu_ok = aok; e.alu = alu;
    e.wr = wr; e.ctl = ctl; e.r1 = r1; e.r2 = r2;
    return e;
  endfunction

  // Reference model: computes the architectural result of each instruction directly.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p4,
                                 input logic [31:0] va, input logic [31:0] vb);
    logic [5:0]  opc, f;
    logic [4:0]  s, t, d, sa;
    logic [31:0] se, ze, res, tg;
    logic        have, rw, mw, mr, jl, hw, sc, hl, tk;
    logic [4:0]  dst, i1, i2;
    opc = i[31:26]; s = i[25:21]; t = i[20:16]; d = i[15:11]; sa = i[10:6]; f = i[5:0];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    res = 0; tg = 0; dst = 0; i1 = s; i2 = t;
    {have, rw, mw, mr, jl, hw, sc, hl, tk} = '0;
    case (opc)
      6'h00: begin
        have = 1; rw = 1; dst = d;
        case (f)
          6'h20, 6'h21: res = va + vb;
          6'h22, 6'h23: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h26: res = va ^ vb;
          6'h27: res = ~(va | vb);
          6'h2A: res = ($signed(va) < $signed(vb)) ? 1 : 0;
          6'h2B: res = (va < vb) ? 1 : 0;
          6'h00: res = vb << sa;
          6'h02: res = vb >> sa;
          6'h03: res = $signed(vb) >>> sa;
          6'h08: begin have = 0; rw = 0; tk = 1; tg = va; end
          6'h0C: begin have = 0; rw = 0; sc = 1; hl = (va == 10); i1 = 2; i2 = 4; end
          default: begin have = 0; rw = 0; end
        endcase
      end
      6'h08, 6'h09: begin have = 1; rw = 1; dst = t; res = va + se; end
      6'h0A: begin have = 1; rw = 1; dst = t; res = ($signed(va) < $signed(se)) ? 1 : 0; end
      6'h0B: begin have = 1; rw = 1; dst = t; res = (va < se) ? 1 : 0; end
      6'h0C: begin have = 1; rw = 1; dst = t; res = va & ze; end
      6'h0D: begin have = 1; rw = 1; dst = t; res = va | ze; end
      6'h0E: begin have = 1; rw = 1; dst = t; res = va ^ ze; end
      6'h23: begin have = 1; rw = 1; mr = 1; dst = t; res = va + se; end
      6'h2B: begin have = 1; mw = 1; res = va + se; end
      6'h29: begin have = 1; mw = 1; hw = 1; res = va + se; end
      6'h04: begin tk = (va == vb); tg = p4 + se * 4; end
      6'h05: begin tk = (va != vb); tg = p4 + se * 4; end
      6'h01: begin tk = (t == 1) && ($signed(va) >= 0); tg = p4 + se * 4; end
      6'h02: begin tk = 1; tg = {p4[31:28], i[25:0], 2'b00}; end
      6'h03: begin tk = 1; tg = {p4[31:28], i[25:0], 2'b00}; rw = 1; jl = 1; dst = 31; end
      default: ;
    endcase
    return mk_e(tk, tg, have, res, dst, {rw, mw, mr, jl, hw, sc, hl}, i1, i2);
  endfunction

  task automatic run_one(input string nm, input logic [31:0] i_ir, input logic [31:0] i_pc4,
                         input logic [31:0] i_a, input logic [31:0] i_b, input exp_t e);
    @(negedge clk);
    ir = i_ir; pc4 = i_pc4; a = i_a; b = i_b; clr = 0; flush = 0;
    #1;
    chk({nm, ".r1_idx"}, {27'b0, r1_idx}, {27'b0, e.r1});
    chk({nm, ".r2_idx"}, {27'b0, r2_idx}, {27'b0, e.r2});
    chk({nm, ".taken"}, {31'b0, taken}, {31'b0, e.taken});
    if (e.taken) chk({nm, ".target"}, target, e.tgt);
    @(posedge clk); #1;
    chk({nm, ".m_pc"}, m_pc, e.taken ? e.tgt : i_pc4);
    chk({nm, ".m_ir"}, m_ir, i_ir);
    chk({nm, ".m_b"}, m_b, i_b);
    chk({nm, ".m_link"}, m_link, i_pc4);
    chk({nm, ".ctl"}, {25'b0, m_regwrite, m_memwrite, m_memtoreg, m_jal, m_sh, m_syscall, m_halt},
        {25'b0, e.ctl});
    if (e.alu_ok) chk({nm, ".m_alu"}, m_alu, e.alu);
    if (e.ctl[6]) chk({nm, ".m_wr"}, {27'b0, m_wr}, {27'b0, e.wr});
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".m_pc"}, m_pc, 0);
    chk({nm, ".m_ir"}, m_ir, 0);
    chk({nm, ".m_alu"}, m_alu, 0);
    chk({nm, ".m_b"}, m_b, 0);
    chk({nm, ".m_link"}, m_link, 0);
    chk({nm, ".m_wr"}, {27'b0, m_wr}, 0);
    chk({nm, ".ctl"}, {25'b0, m_regwrite, m_memwrite, m_memtoreg, m_jal, m_sh, m_syscall, m_halt}, 0);
  endtask

  // Drive a valid instruction with a clear/flush combination for one edge.
  task automatic bubble(input string nm, input logic c, input logic f,
                        input logic [31:0] i_ir, input logic [31:0] i_a, input logic [31:0] i_b);
    @(negedge clk);
    ir = i_ir; pc4 = 32'h500; a = i_a; b = i_b; clr = c; flush = f;
    @(posedge clk); #1;
    check_zero(nm);
  endtask

  vec_t tbl[$];

  function automatic vec_t mk_v(input string nm, input logic [31:0] i_ir, input logic [31:0] i_pc4,
                                input logic [31:0] i_a, input logic [31:0] i_b, input exp_t e);
    vec_t v;
    v.nm = nm; v.ir = i_ir; v.pc4 = i_pc4; v.a = i_a; v.b = i_b; v.e = e;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[19];
    logic [5:0] fns[17];
    logic [31:0] rir, ra, rb, rp;
    exp_t re;

    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B,
            6'h23, 6'h2B, 6'h29, 6'h04, 6'h05, 6'h01, 6'h02, 6'h03, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h3F, 6'h01};

    //        name      ir            pc4           a             b                 tk tgt          aok alu           wr  ctl          r1  r2
    tbl.push_back(mk_v("addi",  32'h2008FFFB, 32'h20,  32'h0,        32'h0,        mk_e(0, 0,       1, 32'hFFFFFFFB, 8,  7'b1000000, 0,  8)));
    tbl.push_back(mk_v("beq_t", 32'h10220003, 32'h100, 32'h7,        32'h7,        mk_e(1, 32'h10C, 0, 0,            0,  7'b0000000, 1,  2)));
    tbl.push_back(mk_v("beq_n", 32'h10220003, 32'h100, 32'h7,        32'h8,        mk_e(0, 0,       0, 0,            0,  7'b0000000, 1,  2)));
    tbl.push_back(mk_v("jal",   32'h0C000040, 32'h1004,32'h0,        32'h0,        mk_e(1, 32'h100, 0, 0,            31, 7'b1001000, 0,  0)));
    tbl.push_back(mk_v("sys_h", 32'h0000000C, 32'h40,  32'd10,       32'h55,       mk_e(0, 0,       0, 0,            0,  7'b0000011, 2,  4)));
    tbl.push_back(mk_v("sys_n", 32'h0000000C, 32'h40,  32'd1,        32'h55,       mk_e(0, 0,       0, 0,            0,  7'b0000010, 2,  4)));
    tbl.push_back(mk_v("sra",   32'h00095103, 32'h60,  32'h0,        32'h80000000, mk_e(0, 0,       1, 32'hF8000000, 10, 7'b1000000, 0,  9)));
    tbl.push_back(mk_v("sltu",  32'h0109502B, 32'h64,  32'h1,        32'hFFFFFFFF, mk_e(0, 0,       1, 32'h1,        10, 7'b1000000, 8,  9)));
    tbl.push_back(mk_v("slt",   32'h0109502A, 32'h68,  32'h1,        32'hFFFFFFFF, mk_e(0, 0,       1, 32'h0,        10, 7'b1000000, 8,  9)));
    tbl.push_back(mk_v("bne_t", 32'h14220003, 32'h200, 32'h1,        32'h2,        mk_e(1, 32'h20C, 0, 0,            0,  7'b0000000, 1,  2)));
    tbl.push_back(mk_v("bgez_t",32'h0421FFFE, 32'h300, 32'h5,        32'h0,        mk_e(1, 32'h2F8, 0, 0,            0,  7'b0000000, 1,  1)));
    tbl.push_back(mk_v("bgez_n",32'h0421FFFE, 32'h300, 32'h80000000, 32'h0,        mk_e(0, 0,       0, 0,            0,  7'b0000000, 1,  1)));
    tbl.push_back(mk_v("jr",    32'h03E00008, 32'h400, 32'h4000,     32'h0,        mk_e(1, 32'h4000,0, 0,            0,  7'b0000000, 31, 0)));
    tbl.push_back(mk_v("lw",    32'h8D280008, 32'h404, 32'h1000,     32'h9,        mk_e(0, 0,       1, 32'h1008,     8,  7'b1010000, 9,  8)));
    tbl.push_back(mk_v("sh",    32'hA528FFFC, 32'h408, 32'h1000,     32'hBEEF,     mk_e(0, 0,       1, 32'hFFC,      0,  7'b0100100, 9,  8)));
    tbl.push_back(mk_v("ori",   32'h34088000, 32'h40C, 32'h1,        32'h0,        mk_e(0, 0,       1, 32'h8001,     8,  7'b1000000, 0,  8)));
    tbl.push_back(mk_v("unk",   32'hFC000000, 32'h410, 32'h3,        32'h3,        mk_e(0, 0,       0, 0,            0,  7'b0000000, 0,  0)));
    tbl.push_back(mk_v("nor",   32'h01095027, 32'h414, 32'h0F0F0000, 32'h00FF00FF, mk_e(0, 0,       1, 32'hF000FF00, 10, 7'b1000000, 8,  9)));

    // Reset state.
    clr = 1; flush = 0; ir = 32'h01095020; pc4 = 32'h10; a = 1; b = 2;
    @(posedge clk); #1;
    check_zero("reset");

    foreach (tbl[k]) run_one(tbl[k].nm, tbl[k].ir, tbl[k].pc4, tbl[k].a, tbl[k].b, tbl[k].e);

    // clr one edge after a valid add, then flush, flush over a taken branch, and both.
    run_one("add_pre", 32'h01095020, 32'h500, 32'h3, 32'h4, mk_e(0, 0, 1, 32'h7, 10, 7'b1000000, 8, 9));
    bubble("clr", 1, 0, 32'h01095020, 32'h3, 32'h4);
    run_one("add_pre2", 32'h01095020, 32'h500, 32'h5, 32'h6, mk_e(0, 0, 1, 32'hB, 10, 7'b1000000, 8, 9));
    bubble("flush", 0, 1, 32'h01095020, 32'h5, 32'h6);
    @(negedge clk);
    ir = 32'h10220003; pc4 = 32'h100; a = 7; b = 7; clr = 0; flush = 1;
    #1 chk("flush_br.taken", {31'b0, taken}, 1);
    @(posedge clk); #1;
    check_zero("flush_br");
    bubble("clr_flush", 1, 1, 32'h0C000040, 32'h0, 32'h0);
    run_one("post", 32'h2008FFFB, 32'h20, 32'h0, 32'h0, mk_e(0, 0, 1, 32'hFFFFFFFB, 8, 7'b1000000, 0, 8));

    // Randomized instructions against the reference model.
    for (int k = 0; k < 400; k++) begin
      rir = $urandom;
      rir[31:26] = ops[$urandom_range(0, 18)];
      if (rir[31:26] == 6'h00) rir[5:0] = fns[$urandom_range(0, 16)];
      if (rir[31:26] == 6'h01) rir[20:16] = 5'($urandom_range(0, 2));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'd10;
        2: ra = {1'b1, 31'($urandom)};
        default: ;
      endcase
      rp = {$urandom, 2'b00};
      re = model(rir, rp, ra, rb);
      run_one($sformatf("rnd%0d", k), rir, rp, ra, rb, re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
